i2f_arbiter: RTL and testbench

I2F_ARBITER -- requirements
Module: i2f_arbiter

---
 rtl/i2f_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 23 ++
 rtl/i2f_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_i2f_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2f_arb_pkg.sv
// Shared FSM state type and constants for the int-to-float converter arbiter.
package i2f_arb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_SEND,
    S_WAIT,
    S_RETURN
  } state_e;

  localparam logic [31:0] I2F_NAN = 32'h7FC0_0000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: lowest request index at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  // Walk from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    winner = ptr;
    any    = |req;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[(int'(ptr) + off) % N]) begin
        winner = IW'((int'(ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/i2f_arbiter.sv
// Shares one int_to_float converter among N_REQ requesters, round-robin, one job at a time; adds 4 cycles.
// Optional converter watchdog under I2F_ARB_TIMEOUT_EN returns NaN and pulses err on expiry.
module i2f_arbiter
  import i2f_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [32*N_REQ-1:0]        req_a,
  input  logic [N_REQ-1:0]           req_stb,
  output logic [N_REQ-1:0]           req_ack,
  output logic [31:0]                rsp_z,
  output logic [N_REQ-1:0]           rsp_stb,
  input  logic [N_REQ-1:0]           rsp_ack,
  output logic [31:0]                cvt_a,
  output logic                       cvt_a_stb,
  input  logic                       cvt_a_ack,
  input  logic [31:0]                cvt_z,
  input  logic                       cvt_z_stb,
  output logic                       cvt_z_ack,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       err
);

  localparam int IW = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_e           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [N_REQ-1:0] req_ack_q, req_ack_d;
  logic [N_REQ-1:0] rsp_stb_q, rsp_stb_d;
  logic [31:0]      cvt_a_q, cvt_a_d;
  logic             cvt_a_stb_q, cvt_a_stb_d;
  logic             cvt_z_ack_q, cvt_z_ack_d;
  logic [31:0]      rsp_z_q, rsp_z_d;
  logic             busy_q, busy_d;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

`ifdef I2F_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req    (req_stb),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    req_ack_d   = req_ack_q;
    rsp_stb_d   = rsp_stb_q;
    cvt_a_d     = cvt_a_q;
    cvt_a_stb_d = cvt_a_stb_q;
    cvt_z_ack_d = cvt_z_ack_q;
    rsp_z_d     = rsp_z_q;
`ifdef I2F_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          grant_d   = pick_idx;
          req_ack_d = ONE << pick_idx;
          state_d   = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        cvt_a_d     = req_a[int'(grant_q)*32 +: 32];
        req_ack_d   = '0;
        cvt_a_stb_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (cvt_a_stb_q && cvt_a_ack) begin
          cvt_a_stb_d = 1'b0;
          cvt_z_ack_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cvt_z_stb && cvt_z_ack_q) begin
          rsp_z_d     = cvt_z;
          cvt_z_ack_d = 1'b0;
          rsp_stb_d   = ONE << grant_q;
          state_d     = S_RETURN;
        end
      end
      S_RETURN: begin
        if (rsp_stb_q[grant_q] && rsp_ack[grant_q]) begin
          rsp_stb_d = '0;
          ptr_d     = (grant_q == IW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef I2F_ARB_TIMEOUT_EN
    // A converter result landing on the expiry cycle takes priority over the NaN.
    if (state_q == S_ACCEPT) begin
      cnt_d = '0;
    end else if (state_q == S_SEND || state_q == S_WAIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(TIMEOUT_CYC) && !(state_q == S_WAIT && cvt_z_stb && cvt_z_ack_q)) begin
        rsp_z_d     = I2F_NAN;
        err_d       = 1'b1;
        cvt_a_stb_d = 1'b0;
        cvt_z_ack_d = 1'b0;
        rsp_stb_d   = ONE << grant_q;
        state_d     = S_RETURN;
      end
    end
`endif
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      req_ack_q   <= '0;
      rsp_stb_q   <= '0;
      cvt_a_q     <= '0;
      cvt_a_stb_q <= 1'b0;
      cvt_z_ack_q <= 1'b0;
      rsp_z_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      req_ack_q   <= req_ack_d;
      rsp_stb_q   <= rsp_stb_d;
      cvt_a_q     <= cvt_a_d;
      cvt_a_stb_q <= cvt_a_stb_d;
      cvt_z_ack_q <= cvt_z_ack_d;
      rsp_z_q     <= rsp_z_d;
      busy_q      <= busy_d;
    end
  end

`ifdef I2F_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
  assign err = 1'b0;
`endif

  assign req_ack   = req_ack_q;
  assign rsp_stb   = rsp_stb_q;
  assign rsp_z     = rsp_z_q;
  assign cvt_a     = cvt_a_q;
  assign cvt_a_stb = cvt_a_stb_q;
  assign cvt_z_ack = cvt_z_ack_q;
  assign busy      = busy_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_i2f_arbiter.sv
// Scoreboard bench for i2f_arbiter with a Q16.16 int_to_float converter stub.
module tb_i2f_arbiter;

  logic         clk;
  logic         rst_n;
  logic [127:0] req_a;
  logic [3:0]   req_stb;
  logic [3:0]   req_ack;
  logic [31:0]  rsp_z;
  logic [3:0]   rsp_stb;
  logic [3:0]   rsp_ack;
  logic [31:0]  cvt_a;
  logic         cvt_a_stb;
  logic         cvt_a_ack;
  logic [31:0]  cvt_z;
  logic         cvt_z_stb;
  logic         cvt_z_ack;
  logic         busy;
  logic [1:0]   grant_id;
  logic         err;

  i2f_arbiter #(.N_REQ(4), .TIMEOUT_CYC(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_stb   (req_stb),
    .req_ack   (req_ack),
    .rsp_z     (rsp_z),
    .rsp_stb   (rsp_stb),
    .rsp_ack   (rsp_ack),
    .cvt_a     (cvt_a),
    .cvt_a_stb (cvt_a_stb),
    .cvt_a_ack (cvt_a_ack),
    .cvt_z     (cvt_z),
    .cvt_z_stb (cvt_z_stb),
    .cvt_z_ack (cvt_z_ack),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] z;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          errcnt = 0;
  logic [31:0] ops[4][16];
  int          wr[4];
  int          rd[4];
  logic        cvt_dead;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input int idx, input logic [31:0] op, input logic push, input logic [31:0] z);
    exp_t e;
    ops[idx][wr[idx]] = op;
    wr[idx]++;
    if (push) begin
      e.idx = 2'(idx);
      e.z   = z;
      sbq.push_back(e);
    end
  endtask

  // Converter behaviour: signed Q16.16 fixed point to single precision, truncating.
  function automatic logic [31:0] q16_to_f(input logic [31:0] a);
    logic [31:0] m;
    int          p;
    if (a == 32'd0) return 32'd0;
    m = a[31] ? (~a + 32'd1) : a;
    p = 31;
    while (!m[p]) p--;
    m = m << (31 - p);
    return {a[31], 8'(127 + p - 16), m[30:8]};
  endfunction

  task automatic chk_idle_outputs(input string nm);
    chk({nm, "_req_ack"}, {28'd0, req_ack}, 32'd0);
    chk({nm, "_rsp_stb"}, {28'd0, rsp_stb}, 32'd0);
    chk({nm, "_cvt_a_stb"}, {31'd0, cvt_a_stb}, 32'd0);
    chk({nm, "_cvt_z_ack"}, {31'd0, cvt_z_ack}, 32'd0);
    chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    chk({nm, "_err"}, {31'd0, err}, 32'd0);
    chk({nm, "_rsp_z"}, rsp_z, 32'd0);
    chk({nm, "_cvt_a"}, cvt_a, 32'd0);
    chk({nm, "_grant_id"}, {30'd0, grant_id}, 32'd0);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outputs(nm);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while ((sbq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sbq.size() != 0 || busy) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d busy=%b, want pending=0 busy=0", nm, sbq.size(), busy);
    end
  endtask

  // Requesters: hold stb and data until the ack edge, then present the next queued operand.
  initial begin
    logic [3:0] xfer;
    req_stb = '0;
    req_a   = '0;
    for (int i = 0; i < 4; i++) begin
      wr[i] = 0;
      rd[i] = 0;
    end
    forever begin
      @(negedge clk);
      xfer = req_stb & req_ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (xfer[i]) req_stb[i] = 1'b0;
        if (!req_stb[i] && rd[i] != wr[i]) begin
          req_a[32*i +: 32] = ops[i][rd[i]];
          rd[i]++;
          req_stb[i] = 1'b1;
        end
      end
    end
  end

  // Converter stub: always accepts, answers 2 cycles later unless cvt_dead.
  initial begin
    logic [31:0] op;
    cvt_a_ack = 1'b1;
    cvt_z_stb = 1'b0;
    cvt_z     = '0;
    forever begin
      @(negedge clk);
      if (rst_n && cvt_a_stb && cvt_a_ack) begin
        op = cvt_a;
        @(posedge clk);
        #1;
        if (!cvt_dead) begin
          repeat (2) @(posedge clk);
          #1;
          cvt_z     = q16_to_f(op);
          cvt_z_stb = 1'b1;
          for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (cvt_z_ack || !rst_n) break;
          end
          @(posedge clk);
          #1 cvt_z_stb = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every result handshake and watches one-hot/grant invariants.
  initial begin
    exp_t       e;
    logic [3:0] g1h;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        g1h = 4'b0001 << grant_id;
        if (req_ack != 4'd0) chk("req_ack_at_grant", {28'd0, req_ack}, {28'd0, g1h});
        if (rsp_stb != 4'd0) chk("rsp_stb_at_grant", {28'd0, rsp_stb}, {28'd0, g1h});
        if (err) errcnt++;
        for (int i = 0; i < 4; i++) begin
          if (rsp_stb[i] && rsp_ack[i]) begin
            if (sbq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_rsp: got idx=%0d z=%h, want no response", i, rsp_z);
            end else begin
              e = sbq.pop_front();
              chk("rsp_idx", 32'(i), {30'd0, e.idx});
              chk("rsp_z", rsp_z, e.z);
            end
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    rsp_ack  = 4'b1111;
    cvt_dead = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request.
    @(negedge clk);
    issue(0, 32'h0001_0000, 1'b1, 32'h3F80_0000);
    wait_drain("single");

    // All four at once after reset: served 0,1,2,3.
    do_reset("rst2");
    @(negedge clk);
    for (int i = 0; i < 4; i++) issue(i, 32'h0004_0000, 1'b1, 32'h4080_0000);
    wait_drain("simul");

    // Requesters 1 and 3 re-requesting: grants alternate 1,3,1,3 (includes zero operand).
    @(negedge clk);
    issue(1, 32'h0002_0000, 1'b1, 32'h4000_0000);
    issue(3, 32'h0003_0000, 1'b1, 32'h4040_0000);
    issue(1, 32'h0000_8000, 1'b1, 32'h3F00_0000);
    issue(3, 32'h0000_0000, 1'b1, 32'h0000_0000);
    wait_drain("fair");

    // Result backpressure on requester 2.
    @(negedge clk);
    rsp_ack[2] = 1'b0;
    issue(2, 32'h0001_8000, 1'b1, 32'h3FC0_0000);
    n = 0;
    while (!rsp_stb[2] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_stb_seen", {28'd0, rsp_stb}, 32'h0000_0004);
    repeat (10) begin
      @(negedge clk);
      chk("bp_stb_hold", {28'd0, rsp_stb}, 32'h0000_0004);
      chk("bp_z_hold", rsp_z, 32'h3FC0_0000);
      chk("bp_busy", {31'd0, busy}, 32'd1);
    end
    @(posedge clk);
    #1 rsp_ack[2] = 1'b1;
    wait_drain("bp");

    // Negative operand.
    @(negedge clk);
    issue(0, 32'hFFFF_0000, 1'b1, 32'hBF80_0000);
    wait_drain("neg");

`ifdef I2F_ARB_TIMEOUT_EN
    // Dead converter: NaN, one err pulse, back to idle.
    @(negedge clk);
    cvt_dead = 1'b1;
    issue(1, 32'h0001_0000, 1'b1, 32'h7FC0_0000);
    wait_drain("tmo");
    repeat (3) @(negedge clk);
    chk("tmo_errcnt", 32'(errcnt), 32'd1);
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    cvt_dead = 1'b0;
`endif

    // Reset while waiting on the converter: discarded, then a fresh request completes.
    @(negedge clk);
    cvt_dead = 1'b1;
    issue(2, 32'h0001_0000, 1'b0, 32'h0);
    n = 0;
    while (!cvt_z_ack && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("midwait_reached", {31'd0, cvt_z_ack}, 32'd1);
    do_reset("rst_wait");
    @(negedge clk);
    cvt_dead = 1'b0;
    issue(3, 32'h0004_0000, 1'b1, 32'h4080_0000);
    wait_drain("post_rst");

    repeat (3) @(negedge clk);
`ifdef I2F_ARB_TIMEOUT_EN
    chk("final_errcnt", 32'(errcnt), 32'd1);
`else
    chk("final_errcnt", 32'(errcnt), 32'd0);
`endif
    chk("final_sbq_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
